alu_iter_stage: RTL and testbench
=================================

ALU_ITER_STAGE -- requirements
Module: alu_iter_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, command valid.
REQ-004 SHALL have port in_ready, output, 1, command accepted when in_valid and in_ready are both high on a clock edge.
REQ-005 SHALL have port in_op, input, 3, ALU opcode, forwarded unmodified.
REQ-006 SHALL have port in_b, input, 8, B operand, or load value when in_load is high.
REQ-007 SHALL have port in_cnt, input, 3, iteration count minus one (1..8 applications).
REQ-008 SHALL have port in_load, input, 1, load in_b into the accumulator; no ALU use.
REQ-009 SHALL have ports alu_a, alu_b, alu_op, outputs, 8/8/3, drive the downstream ALU A/B/OP.
REQ-010 SHALL have ports alu_y, alu_c, alu_v, alu_n, alu_z, inputs, 8/1/1/1/1, combinational ALU results.
REQ-011 SHALL have ports out_valid, input out_ready, outputs out_y (8) and out_flags (4, order C,V,N,Z MSB..LSB), result handshake.

Function
REQ-012 SHALL use three states: IDLE, RUN and DONE.
REQ-013 SHALL hold an 8-bit accumulator ACC, 4-bit flag register FLG, 3-bit counter CNT, and latched OPR (op) and BR (b).
REQ-014 SHALL assert in_ready only in IDLE.
REQ-015 SHALL, on acceptance with in_load=0, latch op, b and CNT=in_cnt, then enter RUN.
REQ-016 SHALL, on acceptance with in_load=1, set ACC=in_b and FLG={0,0,in_b[7],in_b==0}, then enter DONE, without visiting RUN.
REQ-017 SHALL, in RUN, drive alu_a=ACC, alu_b=BR, alu_op=OPR.
REQ-018 SHALL, in RUN, capture ACC=alu_y and FLG={alu_c,alu_v,alu_n,alu_z} every cycle.
REQ-019 SHALL, in RUN, go to DONE after the capture when CNT==0; otherwise it SHALL decrement CNT.
REQ-020 SHALL make a command with in_cnt=k occupy exactly k+1 RUN cycles; out_valid SHALL rise the cycle after the last RUN cycle.
REQ-021 SHALL, outside RUN, drive alu_a=ACC, alu_b=0 and alu_op=OPR; the ALU results SHALL be ignored.
REQ-022 SHALL assert out_valid only in DONE, with out_y=ACC and out_flags=FLG held stable until out_ready.
REQ-023 SHALL return DONE to IDLE on out_valid&&out_ready; the earliest next acceptance SHALL be the following cycle, with no same-cycle bypass.
REQ-024 SHALL keep ACC across commands; each command operates on the previous result.
REQ-025 SHALL ignore in_* changes while not in IDLE; latched values SHALL be unaffected.
REQ-026 SHALL NOT depend on out_ready in IDLE or RUN.

Reset
REQ-027 SHALL, while rst_n is low, force state=IDLE, ACC=0, FLG=0, CNT=0, OPR=0, BR=0, out_valid=0 and in_ready=1, asynchronously.
REQ-028 SHALL abort any RUN or DONE on mid-operation reset, with no result emitted.
REQ-029 SHALL deassert reset synchronously to clk internally (two-flop reset synchroniser on the release edge).

Structure
REQ-030 SHALL take state encoding (IDLE/RUN/DONE) and the flag bit indices from a shared package alu_pkg.
REQ-031 SHALL instantiate one natural sub-module, alu_iter_ctrl (FSM plus counter); the datapath registers SHALL stay in the top.

Verification
REQ-032 SHALL cover load: in_load=1, in_b=0x80 -> out_y=0x80, out_flags=4'b0010 one cycle after accept.
REQ-033 SHALL cover an iterated add (bench ALU stub Y=A+B mod 256, C=carry-out): ACC=0x10, in_b=0x20, in_cnt=2 -> 3 RUN cycles, out_y=0x70, C=0, Z=0.
REQ-034 SHALL cover wrap: ACC=0xFF, in_b=0x01, in_cnt=0 -> out_y=0x00, flags C=1, Z=1; one RUN cycle.
REQ-035 SHALL cover back-pressure: out_ready low 5 cycles -> out_valid, out_y and out_flags stable, in_ready=0 throughout.
REQ-036 SHALL cover mid-run reset: rst_n low during the 2nd RUN cycle of in_cnt=7 -> out_valid=0, ACC=0, in_ready=1 immediately.
REQ-037 SHALL cover ignored input: in_* toggled during RUN -> result identical to an undisturbed run.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterating ALU stage:
//   - datapath / opcode / counter / flag widths
//   - flag bit positions inside the 4-bit flag word (C,V,N,Z from MSB to LSB)
//   - FSM state encoding (IDLE / RUN / DONE)
//   - load_flags(): flag word produced by a direct accumulator load
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DW  = 8;  // accumulator / operand width
  localparam int OPW = 3;  // ALU opcode width
  localparam int CW  = 3;  // iteration counter width (count minus one)
  localparam int FW  = 4;  // flag word width

  // Flag bit indices inside the flag word.
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A load bypasses the ALU, so carry and overflow are cleared and only the
  // sign and zero flags describe the loaded value.
  function automatic logic [FW-1:0] load_flags(input logic [DW-1:0] value);
    logic [FW-1:0] f;
    f        = '0;
    f[FLG_N] = value[DW-1];
    f[FLG_Z] = (value == '0);
    return f;
  endfunction

endpackage

// File: rtl/alu_iter_ctrl.sv
// -----------------------------------------------------------------------------
// alu_iter_ctrl
// Control FSM and iteration counter for alu_iter_stage.
//   clk, rst_n    : clock and (already synchronised) asynchronous active-low reset
//   i_in_valid    : command valid from upstream
//   i_in_load     : command is a direct accumulator load (no RUN phase)
//   i_in_cnt      : iteration count minus one for ALU commands
//   i_out_ready   : downstream accepts the result
//   o_in_ready    : registered, high only in IDLE
//   o_out_valid   : registered, high only in DONE
//   o_accept      : command handshake completes on this edge
//   o_state       : current FSM state (datapath uses it to gate the ALU)
// -----------------------------------------------------------------------------
module alu_iter_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  input  logic          i_in_load,
  input  logic [CW-1:0] i_in_cnt,
  input  logic          i_out_ready,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic          o_accept,
  output state_t        o_state
);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_accept;

  // r_in_ready is high exactly in IDLE, so this is the only place a command
  // can be taken; anything on in_* during RUN/DONE is simply not looked at.
  assign w_accept = i_in_valid & r_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (i_in_load) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= i_in_cnt;
            end
          end
        end
        ST_RUN: begin
          // The datapath captures the ALU result on every RUN edge, including
          // this one, so count k yields exactly k+1 captures.
          if (r_cnt == '0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // Return to IDLE only; a new command is taken no earlier than the
          // next edge because in_ready is still low on this one.
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_accept    = w_accept;
  assign o_state     = r_state;

endmodule

// File: rtl/alu_iter_stage.sv
// -----------------------------------------------------------------------------
// alu_iter_stage
// Applies an external combinational ALU 1..8 times to an accumulator:
// ACC <= ALU(ACC, B, OP) once per RUN cycle. The accumulator persists across
// commands, so each command continues from the previous result. A load command
// writes the accumulator directly without using the ALU.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : command handshake
//   in_op, in_b, in_cnt, in_load : command fields (latched on acceptance)
//   alu_a, alu_b, alu_op       : operands driven to the downstream ALU
//   alu_y, alu_c/v/n/z         : combinational ALU result and flags
//   out_valid/out_ready        : result handshake
//   out_y, out_flags           : accumulator and flags {C,V,N,Z}
// -----------------------------------------------------------------------------
module alu_iter_stage
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [DW-1:0]  in_b,
  input  logic [CW-1:0]  in_cnt,
  input  logic           in_load,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_c,
  input  logic           alu_v,
  input  logic           alu_n,
  input  logic           alu_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_y,
  output logic [FW-1:0]  out_flags
);

  logic [1:0]     r_rst_sync;
  logic           w_rst_n;
  logic           w_accept;
  logic           w_run;
  state_t         w_state;
  logic [FW-1:0]  w_alu_flags;

  logic [DW-1:0]  r_acc;
  logic [FW-1:0]  r_flg;
  logic [OPW-1:0] r_opr;
  logic [DW-1:0]  r_br;

  // NOTE: reset asserts asynchronously through both flops but is released two
  // edges after rst_n rises, so no state flop sees the release near an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  alu_iter_ctrl u_ctrl (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .i_in_valid  (in_valid),
    .i_in_load   (in_load),
    .i_in_cnt    (in_cnt),
    .i_out_ready (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_accept    (w_accept),
    .o_state     (w_state)
  );

  assign w_run = (w_state == ST_RUN);

  // Pack the ALU flag inputs using the shared bit positions.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_alu_flags        = '0;
    w_alu_flags[FLG_C] = alu_c;
    w_alu_flags[FLG_V] = alu_v;
    w_alu_flags[FLG_N] = alu_n;
    w_alu_flags[FLG_Z] = alu_z;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_acc <= '0;
      r_flg <= '0;
      r_opr <= '0;
      r_br  <= '0;
    end else begin
      if (w_accept && in_load) begin
        r_acc <= in_b;
        r_flg <= load_flags(in_b);
      end else if (w_run) begin
        r_acc <= alu_y;
        r_flg <= w_alu_flags;
      end

      // OPR/BR keep their last ALU command across loads.
      if (w_accept && !in_load) begin
        r_opr <= in_op;
        r_br  <= in_b;
      end
    end
  end

  // B is zeroed outside RUN so the ALU sees a quiet operand while its result
  // is being ignored.
  assign alu_a     = r_acc;
  assign alu_b     = w_run ? r_br : '0;
  assign alu_op    = r_opr;
  assign out_y     = r_acc;
  assign out_flags = r_flg;

endmodule

// File: tb/tb_alu_iter_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_iter_stage
// Directed bench for alu_iter_stage with an add-only ALU stub
// (Y = A + B mod 256, C = carry out, V = signed overflow, N = Y[7], Z = Y==0).
// -----------------------------------------------------------------------------
module tb_alu_iter_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_b;
  logic [2:0] in_cnt;
  logic       in_load;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_y;
  logic       alu_c;
  logic       alu_v;
  logic       alu_n;
  logic       alu_z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [3:0] out_flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ALU stub
  logic [8:0] sum;
  assign sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_y = sum[7:0];
  assign alu_c = sum[8];
  assign alu_v = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
  assign alu_n = sum[7];
  assign alu_z = (sum[7:0] == 8'h00);

  alu_iter_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_b      (in_b),
    .in_cnt    (in_cnt),
    .in_load   (in_load),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_flags (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait (bounded) for out_valid. lat = cycles from the
  // accepting edge to out_valid; runs = cycles seen with alu_b == b.
  task automatic issue(input logic load, input logic [7:0] b, input logic [2:0] op,
                       input logic [2:0] cnt, input bit disturb,
                       output int lat, output int runs);
    check("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_load  = load;
    in_b     = b;
    in_op    = op;
    in_cnt   = cnt;
    step();
    in_valid = 1'b0;
    in_load  = 1'b0;
    lat  = 0;
    runs = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      if (!load && alu_b === b) runs++;
      if (disturb) begin
        in_valid = ~in_valid;
        in_load  = ~in_load;
        in_b     = in_b ^ 8'hA5;
        in_op    = in_op + 3'd1;
        in_cnt   = in_cnt + 3'd1;
      end
      lat++;
      step();
    end
    in_valid = 1'b0;
    in_load  = 1'b0;
    in_b     = 8'h00;
    in_op    = 3'd0;
    in_cnt   = 3'd0;
    check("out_valid_within_budget", 32'(out_valid), 1);
    check("in_ready_low_in_done", 32'(in_ready), 0);
    check("alu_b_zero_in_done", 32'(alu_b), 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_cleared", 32'(out_valid), 0);
    check("in_ready_back", 32'(in_ready), 1);
  endtask

  int lat, runs;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_b      = 8'h00;
    in_cnt    = 3'd0;
    in_load   = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_y", 32'(out_y), 0);
    check("rst_out_flags", 32'(out_flags), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Load 0x80: valid one cycle after accept, flags N only
    issue(1'b1, 8'h80, 3'd0, 3'd0, 1'b0, lat, runs);
    check("load80_latency", 32'(lat), 0);
    check("load80_y", 32'(out_y), 32'h80);
    check("load80_flags", 32'(out_flags), 32'b0010);
    drain();

    // Iterated add: 0x10 + 3*0x20 = 0x70
    issue(1'b1, 8'h10, 3'd0, 3'd0, 1'b0, lat, runs);
    drain();
    issue(1'b0, 8'h20, 3'd0, 3'd2, 1'b0, lat, runs);
    check("add3_runs", 32'(runs), 3);
    check("add3_latency", 32'(lat), 3);
    check("add3_y", 32'(out_y), 32'h70);
    check("add3_flags", 32'(out_flags), 32'b0000);
    check("add3_alu_op", 32'(alu_op), 0);
    drain();

    // Wrap: 0xFF + 0x01 = 0x00, C and Z set, one RUN cycle
    issue(1'b1, 8'hFF, 3'd0, 3'd0, 1'b0, lat, runs);
    check("loadff_flags", 32'(out_flags), 32'b0010);
    drain();
    issue(1'b0, 8'h01, 3'd0, 3'd0, 1'b0, lat, runs);
    check("wrap_runs", 32'(runs), 1);
    check("wrap_y", 32'(out_y), 32'h00);
    check("wrap_flags", 32'(out_flags), 32'b1001);

    // Back-pressure: result held for 5 cycles with out_ready low
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_y", 32'(out_y), 32'h00);
      check("bp_out_flags", 32'(out_flags), 32'b1001);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    drain();

    // Accumulator carries over: 0x00 + 2*0x03 = 0x06
    issue(1'b0, 8'h03, 3'd0, 3'd1, 1'b0, lat, runs);
    check("persist_runs", 32'(runs), 2);
    check("persist_y", 32'(out_y), 32'h06);
    check("persist_flags", 32'(out_flags), 32'b0000);
    drain();

    // Undisturbed reference: 0x05 + 4*0x07 = 0x21
    issue(1'b1, 8'h05, 3'd0, 3'd0, 1'b0, lat, runs);
    drain();
    issue(1'b0, 8'h07, 3'd5, 3'd3, 1'b0, lat, runs);
    check("quiet_runs", 32'(runs), 4);
    check("quiet_y", 32'(out_y), 32'h21);
    check("quiet_flags", 32'(out_flags), 32'b0000);
    drain();

    // Same command with in_* toggling throughout RUN
    issue(1'b1, 8'h05, 3'd0, 3'd0, 1'b0, lat, runs);
    drain();
    issue(1'b0, 8'h07, 3'd5, 3'd3, 1'b1, lat, runs);
    check("noisy_runs", 32'(runs), 4);
    check("noisy_y", 32'(out_y), 32'h21);
    check("noisy_flags", 32'(out_flags), 32'b0000);
    check("noisy_alu_op", 32'(alu_op), 5);
    drain();

    // Mid-run reset during the 2nd RUN cycle of an 8-iteration command
    in_valid = 1'b1;
    in_b     = 8'h03;
    in_op    = 3'd0;
    in_cnt   = 3'd7;
    step();
    in_valid = 1'b0;
    check("mr_first_run", 32'(alu_b), 32'h03);
    step();
    check("mr_second_run", 32'(alu_b), 32'h03);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_acc", 32'(alu_a), 0);
    check("mr_out_y", 32'(out_y), 0);
    check("mr_in_ready", 32'(in_ready), 1);
    check("mr_alu_b", 32'(alu_b), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("mr_no_result", 32'(out_valid), 0);
    end
    check("mr_idle_ready", 32'(in_ready), 1);

    // Loading zero sets Z only
    issue(1'b1, 8'h00, 3'd0, 3'd0, 1'b0, lat, runs);
    check("load00_y", 32'(out_y), 0);
    check("load00_flags", 32'(out_flags), 32'b0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
